// File: rtl/tick_sched_ctrl_if.sv
// rtl/tick_sched_ctrl_if.sv - timeout-timer control/status bundle for tick_sched_ctrl
//
// Purpose: groups the sale-FSM <-> timing-controller timeout signals.
// Signals:
//   to_start   master->slave  one-cycle pulse, load and start the timeout
//   to_cancel  master->slave  one-cycle pulse, abort the timeout
//   to_pause   master->slave  level, hold the countdown while 1
//   to_load    master->slave  [7:0] timeout seconds sampled on to_start (0 = default)
//   to_remain  slave->master  [7:0] seconds remaining
//   to_busy    slave->master  timer in RUN or HOLD
//   to_expired slave->master  one-cycle pulse when the countdown reaches 0
interface tick_sched_ctrl_if;
  logic       to_start;
  logic       to_cancel;
  logic       to_pause;
  logic [7:0] to_load;
  logic [7:0] to_remain;
  logic       to_busy;
  logic       to_expired;

  modport master (
    output to_start, to_cancel, to_pause, to_load,
    input  to_remain, to_busy, to_expired
  );

  modport slave (
    input  to_start, to_cancel, to_pause, to_load,
    output to_remain, to_busy, to_expired
  );
endinterface

// File: rtl/tick_sched_ctrl.sv
// rtl/tick_sched_ctrl.sv - ms/second/scan tick generator and transaction timeout timer
//
// Purpose: turns the system clock into one-cycle enable pulses (ms tick,
// second tick, display-scan index) and runs the purchase timeout timer.
// Optional macro TICK_FAST_SIM_EN: forces MS_DIV=4 and MS_PER_SEC=10.
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   run_i      in   level, 0 freezes prescaler, second counter and timer
//   tmr        slave modport of tick_sched_ctrl_if (timeout control/status)
//   ms_tick_o  out  one-cycle pulse every MS_DIV cycles
//   sec_tick_o out  one-cycle pulse every MS_PER_SEC ms ticks
//   scan_idx_o out  [2:0] display digit index, wraps at SCAN_DIGITS
module tick_sched_ctrl #(
  parameter int CLK_HZ      = 100000000,
  parameter int MS_PER_SEC  = 1000,
  parameter int SCAN_DIGITS = 8,
  parameter int TIMEOUT_S   = 30
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run_i,
  tick_sched_ctrl_if.slave     tmr,
  output logic                 ms_tick_o,
  output logic                 sec_tick_o,
  output logic [2:0]           scan_idx_o
);

`ifdef TICK_FAST_SIM_EN
  localparam int MS_DIV = 4;
  localparam int MS_SEC = 10;
`else
  localparam int MS_DIV = CLK_HZ / 1000;
  localparam int MS_SEC = MS_PER_SEC;
`endif

  localparam int PRE_W = $clog2(MS_DIV);
  localparam int MS_W  = (MS_SEC > 1) ? $clog2(MS_SEC) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(MS_DIV - 1);
  localparam logic [MS_W-1:0]  MS_MAX   = MS_W'(MS_SEC - 1);
  localparam logic [2:0]       SCAN_MAX = 3'(SCAN_DIGITS - 1);
  localparam logic [7:0]       TO_DFLT  = 8'(TIMEOUT_S);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e           state_q,   state_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [MS_W-1:0]  ms_cnt_q,  ms_cnt_d;
  logic [2:0]       scan_q,    scan_d;
  logic [7:0]       remain_q,  remain_d;
  logic             ms_tick_q, ms_tick_d;
  logic             sec_tick_q, sec_tick_d;
  logic             expired_q, expired_d;

  logic             ms_wrap;
  logic             sec_wrap;

  // Wrap conditions are evaluated one cycle ahead of the registered pulses,
  // so the timer acts on the same edge at which sec_tick_o rises.
  assign ms_wrap  = run_i && (pre_cnt_q == PRE_MAX);
  assign sec_wrap = ms_wrap && (ms_cnt_q == MS_MAX);

  always_comb begin
    pre_cnt_d  = pre_cnt_q;
    ms_cnt_d   = ms_cnt_q;
    scan_d     = scan_q;
    ms_tick_d  = ms_wrap;
    sec_tick_d = sec_wrap;
    state_d    = state_q;
    remain_d   = remain_q;
    expired_d  = 1'b0;

    if (run_i) begin
      pre_cnt_d = ms_wrap ? '0 : pre_cnt_q + PRE_W'(1);
    end
    if (ms_wrap) begin
      ms_cnt_d = sec_wrap ? '0 : ms_cnt_q + MS_W'(1);
      scan_d   = (scan_q == SCAN_MAX) ? 3'd0 : scan_q + 3'd1;
    end

    // Priority: cancel > start > pause > decrement. Start/cancel bypass run.
    if (tmr.to_cancel) begin
      state_d  = ST_IDLE;
      remain_d = 8'd0;
    end else if (tmr.to_start) begin
      state_d   = ST_RUN;
      remain_d  = (tmr.to_load == 8'd0) ? TO_DFLT : tmr.to_load;
      // Realign the second boundary so the first decrement is a full second away.
      pre_cnt_d = '0;
      ms_cnt_d  = '0;
    end else if (run_i) begin
      case (state_q)
        ST_RUN: begin
          if (tmr.to_pause) begin
            state_d = ST_HOLD;
          end else if (sec_wrap) begin
            if (remain_q <= 8'd1) begin
              state_d   = ST_IDLE;
              remain_d  = 8'd0;
              expired_d = 1'b1;
            end else begin
              remain_d = remain_q - 8'd1;
            end
          end
        end
        ST_HOLD: begin
          if (!tmr.to_pause) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pre_cnt_q  <= '0;
      ms_cnt_q   <= '0;
      scan_q     <= 3'd0;
      remain_q   <= 8'd0;
      ms_tick_q  <= 1'b0;
      sec_tick_q <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      ms_cnt_q   <= ms_cnt_d;
      scan_q     <= scan_d;
      remain_q   <= remain_d;
      ms_tick_q  <= ms_tick_d;
      sec_tick_q <= sec_tick_d;
      expired_q  <= expired_d;
    end
  end

  assign ms_tick_o      = ms_tick_q;
  assign sec_tick_o     = sec_tick_q;
  assign scan_idx_o     = scan_q;
  assign tmr.to_remain  = remain_q;
  assign tmr.to_busy    = (state_q != ST_IDLE);
  assign tmr.to_expired = expired_q;

endmodule

// File: tb/tb_tick_sched_ctrl.sv
// tb/tb_tick_sched_ctrl.sv - directed self-checking bench for tick_sched_ctrl
module tb_tick_sched_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       ms_tick;
  logic       sec_tick;
  logic [2:0] scan_idx;

  int n_checks = 0;
  int n_pass   = 0;

  tick_sched_ctrl_if tif ();

  tick_sched_ctrl #(
    .CLK_HZ      (8000),
    .MS_PER_SEC  (4),
    .SCAN_DIGITS (6),
    .TIMEOUT_S   (30)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_i      (run),
    .tmr        (tif.slave),
    .ms_tick_o  (ms_tick),
    .sec_tick_o (sec_tick),
    .scan_idx_o (scan_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int ms_err, sec_err, nms, cnt, k2, k1, kexp, nexp, k29, wait_n;
    logic [2:0] scan_hold;

    tif.to_start = 1'b0; tif.to_cancel = 1'b0; tif.to_pause = 1'b0; tif.to_load = 8'd0;
    run = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_ms_tick", ms_tick, 0);
    check("rst_sec_tick", sec_tick, 0);
    check("rst_scan", scan_idx, 0);
    check("rst_remain", tif.to_remain, 0);
    check("rst_busy", tif.to_busy, 0);
    check("rst_expired", tif.to_expired, 0);
    rst_n = 1'b1;

    // Prescaler / second / scan: ms every 8 edges, sec every 32
    ms_err = 0; sec_err = 0; nms = 0;
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      if (ms_tick !== ((n % 8) == 0)) ms_err++;
      if (sec_tick !== ((n % 32) == 0)) sec_err++;
      if ((n % 8) == 0) begin
        nms++;
        check("scan_idx", scan_idx, nms % 6);
      end
    end
    check("ms_period", ms_err, 0);
    check("sec_period", sec_err, 0);

    // run=0 freeze with prescaler at 3
    repeat (3) @(negedge clk);
    scan_hold = scan_idx;
    run = 1'b0;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ms_tick) cnt++;
    end
    check("frozen_ms_ticks", cnt, 0);
    check("frozen_scan", scan_idx, scan_hold);
    run = 1'b1;
    wait_n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ms_tick && wait_n < 0) wait_n = i;
    end
    check("resume_latency", wait_n, 5);

    // Timeout of 3 s: decrements at 32/64/96, expiry at 96
    do_reset();
    @(negedge clk);
    tif.to_start = 1'b1; tif.to_load = 8'd3;
    @(negedge clk);
    tif.to_start = 1'b0;
    check("load3_remain", tif.to_remain, 3);
    check("load3_busy", tif.to_busy, 1);
    k2 = -1; k1 = -1; kexp = -1; nexp = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k2 < 0 && tif.to_remain == 8'd2) k2 = k;
      if (k1 < 0 && tif.to_remain == 8'd1) k1 = k;
      if (tif.to_expired) begin
        nexp++;
        kexp = k;
        check("expire_busy", tif.to_busy, 0);
        check("expire_remain", tif.to_remain, 0);
      end
    end
    check("dec_to_2_at", k2, 32);
    check("dec_to_1_at", k1, 64);
    check("expire_at", kexp, 96);
    check("expire_pulses", nexp, 1);

    // Default timeout, pause for 100 cycles, resume on original second grid
    tif.to_start = 1'b1; tif.to_load = 8'd0;
    @(negedge clk);
    tif.to_start = 1'b0;
    check("default_remain", tif.to_remain, 30);
    repeat (10) @(negedge clk);
    tif.to_pause = 1'b1;
    repeat (100) @(negedge clk);
    check("hold_remain", tif.to_remain, 30);
    check("hold_busy", tif.to_busy, 1);
    tif.to_pause = 1'b0;
    k29 = -1;
    for (int k = 111; k <= 140; k++) begin
      @(negedge clk);
      if (k29 < 0 && tif.to_remain == 8'd29) k29 = k;
    end
    check("resume_dec_at", k29, 128);

    // Cancel and start together: cancel wins
    tif.to_cancel = 1'b1; tif.to_start = 1'b1; tif.to_load = 8'd7;
    @(negedge clk);
    tif.to_cancel = 1'b0; tif.to_start = 1'b0;
    check("cancel_remain", tif.to_remain, 0);
    check("cancel_busy", tif.to_busy, 0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (tif.to_expired) cnt++;
      @(negedge clk);
    end
    check("cancel_no_expire", cnt, 0);

    // Start coinciding with the 1->0 decrement: reload, no expiry
    tif.to_start = 1'b1; tif.to_load = 8'd1;
    @(negedge clk);
    tif.to_start = 1'b0;
    repeat (31) @(negedge clk);
    check("pre_edge_remain", tif.to_remain, 1);
    tif.to_start = 1'b1; tif.to_load = 8'd5;
    @(negedge clk);
    tif.to_start = 1'b0;
    check("retrig_expired", tif.to_expired, 0);
    check("retrig_remain", tif.to_remain, 5);
    check("retrig_busy", tif.to_busy, 1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tif.to_expired) cnt++;
    end
    check("retrig_no_expire", cnt, 0);

    // Asynchronous reset between edges
    check("pre_async_remain", tif.to_remain, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_ms_tick", ms_tick, 0);
    check("async_sec_tick", sec_tick, 0);
    check("async_scan", scan_idx, 0);
    check("async_remain", tif.to_remain, 0);
    check("async_busy", tif.to_busy, 0);
    check("async_expired", tif.to_expired, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/tick_sched_ctrl.md
Name: tick_sched_ctrl

Overview:
Timing controller for the ticket machine, driven by the divided system clock.
- Turns the free-running clock into one-cycle enable pulses: ms tick, display-scan index, second tick.
- Sequences a transaction timeout timer (start/cancel/pause/expire) used by the sale FSM to abort idle purchases and return coins.
- All consumers stay on the single clock and use these pulses as clock enables; no derived clocks.

Parameters:
CLK_HZ, 100000000, input clock frequency in Hz; CLK_HZ/1000 must be >= 2.
MS_PER_SEC, 1000, ms ticks per second tick.
SCAN_DIGITS, 8, number of 7-segment digits scanned; 2..8.
TIMEOUT_S, 30, default timeout in seconds when to_load is 0; 1..255.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst_n  in  1  asynchronous active-low reset.
run  in  1  level; 0 freezes the prescaler, second counter and timer (pause-all).
to_start  in  1  one-cycle pulse; load and start the timeout.
to_cancel  in  1  one-cycle pulse; abort the timeout.
to_pause  in  1  level; holds the countdown while 1.
to_load  in  8  timeout seconds sampled on to_start; 0 selects TIMEOUT_S.
ms_tick  out  1  one-cycle pulse every CLK_HZ/1000 cycles.
sec_tick  out  1  one-cycle pulse every MS_PER_SEC ms ticks.
scan_idx  out  3  display digit index; advances on each ms_tick.
to_remain  out  8  seconds remaining in the timeout.
to_busy  out  1  1 while the timer is in RUN or HOLD.
to_expired  out  1  one-cycle pulse when the countdown reaches 0.

Behaviour:
- Reset (async, rst_n=0): all counters 0; ms_tick=0, sec_tick=0, scan_idx=0, to_remain=0, to_busy=0, to_expired=0; FSM=IDLE. Release is synchronous to the next clk edge.
- Prescaler: pre_cnt counts 0..MS_DIV-1, where MS_DIV=CLK_HZ/1000.
  - ms_tick=1 (registered) in the cycle after pre_cnt reaches MS_DIV-1, then pre_cnt wraps to 0.
  - Advances only when run=1. With run=0, counters hold and ms_tick=0.
- Second counter: ms_cnt counts ms_ticks 0..MS_PER_SEC-1; sec_tick pulses on the wrap, same cycle as that ms_tick.
- Scan: scan_idx increments on ms_tick and wraps SCAN_DIGITS-1 -> 0. It is not affected by the timer.
- Timer FSM states:
  - IDLE: to_busy=0. On to_start -> RUN, to_remain=(to_load==0 ? TIMEOUT_S : to_load). On the same transition, ms_cnt and pre_cnt clear so the first decrement occurs a full second later.
  - RUN: on sec_tick, to_remain decrements. If to_pause=1 -> HOLD.
  - HOLD: to_remain frozen and sec_tick ignored; to_pause=0 -> RUN. The prescaler keeps running, so the second boundary is not re-aligned.
  - Expiry: on a decrement from 1 to 0, to_expired=1 for exactly one cycle, then -> IDLE with to_remain=0.
- Priority when events coincide in a cycle: to_cancel > to_start > pause > sec_tick decrement.
  - to_cancel in any state -> IDLE, to_remain=0, no to_expired pulse.
  - to_start in RUN/HOLD reloads and restarts (retrigger).
  - to_start together with a 1->0 decrement: reload wins, no to_expired.
- run=0 freezes the timer in its current state; to_start and to_cancel are still accepted.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
Macro TICK_FAST_SIM_EN.
- Defined: MS_DIV is forced to 4 and MS_PER_SEC to 10, overriding the parameters, for fast simulation.
- Not defined: the parameter-derived values are used; behaviour is otherwise identical.

Test Plan:
- CLK_HZ=8000, MS_PER_SEC=4, run=1 from reset -> ms_tick pulses every 8 cycles; sec_tick every 32 cycles, coincident with every 4th ms_tick.
- SCAN_DIGITS=6 -> scan_idx sequence 0,1,2,3,4,5,0 on successive ms_ticks.
- to_start with to_load=3 (CLK_HZ=8000, MS_PER_SEC=4) -> to_remain 3,2,1,0 at 32-cycle spacing; to_expired one pulse after 96 cycles; to_busy falls with it.
- to_start with to_load=0 -> to_remain=TIMEOUT_S (30); to_pause held 100 cycles -> to_remain unchanged; after release the countdown resumes.
- to_cancel and to_start in the same cycle while in RUN -> IDLE, to_remain=0, no to_expired. Separately, to_start at the 1->0 edge -> reload, no to_expired.
- rst_n asserted mid-count, asynchronously between edges -> all outputs 0 immediately. run=0 for 50 cycles -> no ms_tick, and pre_cnt resumes from its held value.
